// File: rtl/arrow_scroll_controller.sv
// rtl/arrow_scroll_controller.sv - chart-driven arrow scroller with per-player timing judgement
module arrow_scroll_controller #(
    parameter logic [18:0] BEAT_CYCLES = 19'd400000,
    parameter logic [8:0]  CHART_LEN   = 9'd256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        frame_end,
    output logic [7:0]  chart_addr,
    output logic        chart_req,
    input  logic [2:0]  chart_data,
    input  logic        chart_valid,
    input  logic [2:0]  p1_buttons,
    input  logic [2:0]  p2_buttons,
    output logic [77:0] arrow_array,
    output logic [1:0]  p1_indicator,
    output logic [1:0]  p2_indicator,
    output logic        playing,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_COMMIT,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t       r_state;
    state_t       w_state_nx;

    logic [7:0]   r_addr;
    logic         r_req;
    logic [2:0]   r_next_code;
    logic [8:0]   r_loaded;
    logic [18:0]  r_beat_cnt;
    logic         r_beat_pending;
    logic [77:0]  r_array;
    logic [4:0]   r_flush_cnt;
    logic [1:0]   r_p1_ind;
    logic [1:0]   r_p2_ind;
    logic [2:0]   r_p1_prev;
    logic [2:0]   r_p2_prev;
    logic         r_p1_judged;
    logic         r_p2_judged;
    logic         r_playing;
    logic         r_done;

    logic         w_active;
    logic         w_wrap;
    logic         w_shift;
    logic         w_capture;
    logic         w_start;
    logic [8:0]   w_loaded_nx;
    logic         w_more_entries;
    logic         w_p1_edge;
    logic         w_p2_edge;
    logic [2:0]   w_slot25;
    logic [2:0]   w_slot24;

    function automatic logic [1:0] judge(input logic [2:0] s25, input logic [2:0] s24,
                                         input logic [2:0] btn);
        if (btn == s25)
            judge = 2'b11;
        else if (btn == s24)
            judge = 2'b10;
        else
            judge = 2'b01;
    endfunction

    assign w_active       = (r_state == S_FETCH) || (r_state == S_WAIT_COMMIT) || (r_state == S_FLUSH);
    assign w_wrap         = w_active && (r_beat_cnt == BEAT_CYCLES - 19'd1);
    // A shift needs a committed code (WAIT_COMMIT) or is a blank flush shift.
    assign w_shift        = frame_end && (r_beat_pending || w_wrap) &&
                            ((r_state == S_WAIT_COMMIT) || (r_state == S_FLUSH));
    assign w_capture      = (r_state == S_FETCH) && r_req && chart_valid;
    assign w_start        = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_loaded_nx    = r_loaded + 9'd1;
    assign w_more_entries = w_loaded_nx < CHART_LEN;
    assign w_p1_edge      = (p1_buttons != 3'b000) && (r_p1_prev == 3'b000);
    assign w_p2_edge      = (p2_buttons != 3'b000) && (r_p2_prev == 3'b000);
    assign w_slot25       = r_array[77:75];
    assign w_slot24       = r_array[74:72];

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start)
                    w_state_nx = S_FETCH;
            end
            S_FETCH: begin
                if (w_capture)
                    w_state_nx = S_WAIT_COMMIT;
            end
            S_WAIT_COMMIT: begin
                if (w_shift)
                    w_state_nx = w_more_entries ? S_FETCH : S_FLUSH;
            end
            S_FLUSH: begin
                if (w_shift && (r_flush_cnt == 5'd25))
                    w_state_nx = S_DONE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr         <= 8'd0;
            r_req          <= 1'b0;
            r_next_code    <= 3'b000;
            r_loaded       <= 9'd0;
            r_beat_cnt     <= 19'd0;
            r_beat_pending <= 1'b0;
            r_array        <= 78'd0;
            r_flush_cnt    <= 5'd0;
            r_p1_ind       <= 2'b00;
            r_p2_ind       <= 2'b00;
            r_p1_prev      <= 3'b000;
            r_p2_prev      <= 3'b000;
            r_p1_judged    <= 1'b0;
            r_p2_judged    <= 1'b0;
            r_playing      <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_playing <= (w_state_nx == S_FETCH) || (w_state_nx == S_WAIT_COMMIT) ||
                         (w_state_nx == S_FLUSH);
            r_done    <= (w_state_nx == S_DONE);
            r_p1_prev <= p1_buttons;
            r_p2_prev <= p2_buttons;

            if (w_start) begin
                r_addr         <= 8'd0;
                r_req          <= 1'b1;
                r_next_code    <= 3'b000;
                r_loaded       <= 9'd0;
                r_beat_cnt     <= 19'd0;
                r_beat_pending <= 1'b0;
                r_array        <= 78'd0;
                r_flush_cnt    <= 5'd0;
                r_p1_ind       <= 2'b00;
                r_p2_ind       <= 2'b00;
                r_p1_judged    <= 1'b0;
                r_p2_judged    <= 1'b0;
            end else begin
                if (w_active)
                    r_beat_cnt <= w_wrap ? 19'd0 : r_beat_cnt + 19'd1;

                if (w_capture) begin
                    r_next_code <= chart_data;
                    r_req       <= 1'b0;
                end

                // Judge against the pre-shift array; a shift then opens a new beat.
                if (w_active && w_p1_edge && !r_p1_judged) begin
                    r_p1_ind    <= judge(w_slot25, w_slot24, p1_buttons);
                    r_p1_judged <= 1'b1;
                end
                if (w_active && w_p2_edge && !r_p2_judged) begin
                    r_p2_ind    <= judge(w_slot25, w_slot24, p2_buttons);
                    r_p2_judged <= 1'b1;
                end

                if (w_shift) begin
                    r_array        <= {r_array[74:0], (r_state == S_FLUSH) ? 3'b000 : r_next_code};
                    r_beat_pending <= 1'b0;
                    r_p1_judged    <= 1'b0;
                    r_p2_judged    <= 1'b0;
                    if (r_state == S_WAIT_COMMIT) begin
                        r_loaded <= w_loaded_nx;
                        if (w_more_entries) begin
                            r_addr <= r_addr + 8'd1;
                            r_req  <= 1'b1;
                        end else begin
                            r_flush_cnt <= 5'd0;
                        end
                    end else begin
                        r_flush_cnt <= r_flush_cnt + 5'd1;
                    end
                end else if (w_wrap) begin
                    r_beat_pending <= 1'b1;
                end
            end
        end
    end

    assign chart_addr   = r_addr;
    assign chart_req    = r_req;
    assign arrow_array  = r_array;
    assign p1_indicator = r_p1_ind;
    assign p2_indicator = r_p2_ind;
    assign playing      = r_playing;
    assign done         = r_done;

endmodule

// File: tb/tb_arrow_scroll_controller.sv
// tb/tb_arrow_scroll_controller.sv - self-checking bench for arrow_scroll_controller
module tb_arrow_scroll_controller;

    localparam int BEAT = 4;
    localparam int CLEN = 2;

    logic        clock = 1'b0;
    logic        reset, start, frame_end, chart_valid;
    logic [2:0]  chart_data, p1_buttons, p2_buttons;
    logic [7:0]  chart_addr;
    logic        chart_req;
    logic [77:0] arrow_array;
    logic [1:0]  p1_indicator, p2_indicator;
    logic        playing, done;

    always #5 clock = ~clock;

    arrow_scroll_controller #(
        .BEAT_CYCLES(19'(BEAT)),
        .CHART_LEN  (9'(CLEN))
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .frame_end   (frame_end),
        .chart_addr  (chart_addr),
        .chart_req   (chart_req),
        .chart_data  (chart_data),
        .chart_valid (chart_valid),
        .p1_buttons  (p1_buttons),
        .p2_buttons  (p2_buttons),
        .arrow_array (arrow_array),
        .p1_indicator(p1_indicator),
        .p2_indicator(p2_indicator),
        .playing     (playing),
        .done        (done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [77:0] got, input logic [77:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 fetching, 2 code held, 3 flushing, 4 done.
    int m_phase, m_tick, m_code, m_entries, m_flushes, m_addr;
    int m_slot [26];
    int m_ind [2];
    int m_prev [2];
    bit m_judged [2];
    bit m_pending, m_req;

    function automatic logic [77:0] m_array();
        logic [77:0] v;
        v = '0;
        for (int k = 0; k < 26; k++)
            v[3*k +: 3] = 3'(m_slot[k]);
        return v;
    endfunction

    task automatic model_clear(input int phase);
        m_phase = phase; m_tick = 0; m_code = 0; m_entries = 0; m_flushes = 0;
        m_addr = 0; m_pending = 0; m_req = (phase == 1);
        for (int k = 0; k < 26; k++) m_slot[k] = 0;
        for (int p = 0; p < 2; p++) begin m_ind[p] = 0; m_judged[p] = 0; end
    endtask

    task automatic model_step(input bit rst, input bit st, input bit fe, input bit vld,
                              input int data, input int b1, input int b2);
        int  btn [2];
        bit  play, wrap, shift;
        btn[0] = b1; btn[1] = b2;
        if (rst) begin
            model_clear(0);
            m_prev[0] = 0; m_prev[1] = 0;
            return;
        end
        play = (m_phase >= 1) && (m_phase <= 3);
        for (int p = 0; p < 2; p++) begin
            if (play && btn[p] != 0 && m_prev[p] == 0 && !m_judged[p]) begin
                m_ind[p]    = (m_slot[25] == btn[p]) ? 3 : (m_slot[24] == btn[p]) ? 2 : 1;
                m_judged[p] = 1;
            end
            m_prev[p] = btn[p];
        end
        if (!play) begin
            if (st) model_clear(1);
            return;
        end
        wrap  = (m_tick % BEAT) == BEAT - 1;
        m_tick++;
        shift = fe && (m_pending || wrap) && (m_phase >= 2);
        if (m_phase == 1 && vld) begin
            m_code = data; m_req = 0; m_phase = 2;
        end else if (shift) begin
            for (int k = 25; k > 0; k--) m_slot[k] = m_slot[k-1];
            m_slot[0] = (m_phase == 2) ? m_code : 0;
            m_pending = 0; m_judged[0] = 0; m_judged[1] = 0;
            if (m_phase == 2) begin
                m_entries++;
                if (m_entries < CLEN) begin m_addr++; m_req = 1; m_phase = 1; end
                else begin m_phase = 3; m_flushes = 0; end
            end else begin
                m_flushes++;
                if (m_flushes == 26) m_phase = 4;
            end
        end
        if (!shift && wrap) m_pending = 1;
    endtask

    logic [2:0] chart_mem [256];
    int  fe_pct, rom_lat, rom_cnt;
    bit  noise, rand_mode;

    function automatic logic [2:0] pick();
        int r;
        r = $urandom_range(9);
        case (r)
            5: return 3'b001;
            6: return 3'b010;
            7: return 3'b011;
            8: return 3'b100;
            9: return 3'b110;
            default: return 3'b000;
        endcase
    endfunction

    task automatic compare_all();
        check_eq("arrow_array", arrow_array, m_array());
        check_eq("chart_req", 78'(chart_req), 78'(m_req));
        check_eq("chart_addr", 78'(chart_addr), 78'(m_addr));
        check_eq("p1_indicator", 78'(p1_indicator), 78'(m_ind[0]));
        check_eq("p2_indicator", 78'(p2_indicator), 78'(m_ind[1]));
        check_eq("playing", 78'(playing), 78'(m_phase >= 1 && m_phase <= 3));
        check_eq("done", 78'(done), 78'(m_phase == 4));
    endtask

    task automatic drive_auto();
        reset     = rand_mode && ($urandom_range(999) < 3);
        start     = rand_mode && ($urandom_range(99) < 2);
        frame_end = ($urandom_range(99) < fe_pct);
        p1_buttons = rand_mode ? pick() : 3'b000;
        p2_buttons = rand_mode ? pick() : 3'b000;
        if (chart_req) begin
            rom_cnt++;
            if (rom_cnt >= rom_lat) begin
                chart_valid = 1'b1;
                chart_data  = chart_mem[chart_addr];
                rom_cnt     = 0;
            end else begin
                chart_valid = 1'b0;
            end
        end else begin
            rom_cnt     = 0;
            chart_valid = noise && ($urandom_range(2) == 0);
            chart_data  = 3'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step(reset, start, frame_end, chart_valid, int'(chart_data),
                   int'(p1_buttons), int'(p2_buttons));
        @(negedge clock);
        compare_all();
        drive_auto();
    endtask

    task automatic start_play();
        start = 1'b1;
        tick();
    endtask

    task automatic run_to_done(input string tag, input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        check_eq(tag, 78'(done), 78'd1);
    endtask

    logic [77:0] snap;

    initial begin
        reset = 1'b1; start = 1'b0; frame_end = 1'b1; chart_valid = 1'b0;
        chart_data = 3'b000; p1_buttons = 3'b000; p2_buttons = 3'b000;
        fe_pct = 100; rom_lat = 3; rom_cnt = 0; noise = 0; rand_mode = 0;
        for (int a = 0; a < 256; a++) chart_mem[a] = 3'b000;
        model_clear(0);
        m_prev[0] = 0; m_prev[1] = 0;
        tick();
        check_eq("rst_arrow", arrow_array, 78'd0);
        check_eq("rst_req", 78'(chart_req), 78'd0);
        check_eq("rst_playing", 78'(playing), 78'd0);

        // Two-entry chart scrolls in then flushes fully.
        chart_mem[0] = 3'b001; chart_mem[1] = 3'b100;
        start_play();
        for (int i = 0; i < 50 && arrow_array == 78'd0; i++) tick();
        check_eq("a_first_shift", arrow_array, 78'd1);
        for (int i = 0; i < 50 && arrow_array[2:0] != 3'b100; i++) tick();
        check_eq("a_second_shift", arrow_array, 78'd12);
        run_to_done("a_done_timeout", 400);
        check_eq("a_flushed", arrow_array, 78'd0);
        check_eq("a_not_playing", 78'(playing), 78'd0);

        // Judgement at the hit row, second press in the same beat ignored.
        chart_mem[0] = 3'b010; chart_mem[1] = 3'b001;
        start_play();
        for (int i = 0; i < 400 && arrow_array[77:75] != 3'b010; i++) tick();
        check_eq("c_slot25", 78'(arrow_array[77:75]), 78'd2);
        check_eq("c_slot24", 78'(arrow_array[74:72]), 78'd1);
        p1_buttons = 3'b010; p2_buttons = 3'b001;
        tick();
        check_eq("c_p1_excellent", 78'(p1_indicator), 78'd3);
        check_eq("c_p2_good", 78'(p2_indicator), 78'd2);
        tick();
        p1_buttons = 3'b011;
        tick();
        check_eq("c_p1_second_press", 78'(p1_indicator), 78'd3);
        run_to_done("c_done_timeout", 400);

        // frame_end withheld: beat waits, then moves exactly one slot.
        chart_mem[0] = 3'b100; chart_mem[1] = 3'b011;
        fe_pct = 0;
        start_play();
        for (int i = 0; i < 16; i++) tick();
        check_eq("d_held", arrow_array, 78'd0);
        frame_end = 1'b1;
        tick();
        check_eq("d_one_slot", arrow_array, 78'd4);
        for (int i = 0; i < 12; i++) tick();
        check_eq("d_held2", arrow_array, 78'd4);
        frame_end = 1'b1;
        tick();
        check_eq("d_one_slot2", arrow_array, 78'd35);
        fe_pct = 100;
        run_to_done("d_done_timeout", 400);

        // Slow ROM, then reset mid-fetch with a late valid.
        rom_lat = 10;
        start_play();
        run_to_done("b_slow_done_timeout", 600);
        start_play();
        tick(); tick();
        reset = 1'b1;
        tick();
        check_eq("b_rst_req", 78'(chart_req), 78'd0);
        check_eq("b_rst_arrow", arrow_array, 78'd0);
        check_eq("b_rst_playing", 78'(playing), 78'd0);
        chart_valid = 1'b1; chart_data = 3'b110;
        tick();
        chart_valid = 1'b1;
        tick();
        check_eq("b_late_valid_req", 78'(chart_req), 78'd0);
        check_eq("b_late_valid_playing", 78'(playing), 78'd0);
        rom_lat = 3;
        start_play();
        check_eq("b_restart_addr", 78'(chart_addr), 78'd0);
        check_eq("b_restart_req", 78'(chart_req), 78'd1);
        run_to_done("b_restart_done_timeout", 400);

        // Randomized traffic against the model.
        for (int a = 0; a < 256; a++) chart_mem[a] = pick();
        rand_mode = 1; noise = 1;
        for (int seg = 0; seg < 12; seg++) begin
            fe_pct  = $urandom_range(100, 20);
            rom_lat = $urandom_range(12, 1);
            start_play();
            for (int i = 0; i < 400; i++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/arrow_scroll_controller.md
ARROW_SCROLL_CONTROLLER -- requirements
Module: arrow_scroll_controller

Interface
REQ-001 The block SHALL have parameter BEAT_CYCLES, default 19'd400000, meaning clock cycles per beat (minimum 2).
REQ-002 The block SHALL have parameter CHART_LEN, default 9'd256, meaning number of chart entries played (1..256).
REQ-003 clock  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin playback.
REQ-006 frame_end  input  1  single-cycle pulse at end of active video, the only legal display-update point.
REQ-007 chart_addr  output  8  chart ROM address of next entry.
REQ-008 chart_req  output  1  chart read request.
REQ-009 chart_data  input  3  arrow code: 001 up, 010 left, 011 down, 100 right, 110 shake, 000 none.
REQ-010 chart_valid  input  1  chart_data valid for the outstanding request.
REQ-011 p1_buttons, p2_buttons  input  3 each  pressed arrow code per player, 000 = none.
REQ-012 arrow_array  output  78  26 slots x 3 bits; slot k = bits [3k+2:3k]; slot 0 top row, slot 25 hit row.
REQ-013 p1_indicator, p2_indicator  output  2 each  11 excellent, 10 good, 01 bad, 00 none.
REQ-014 playing  output  1  high while chart is scrolling.
REQ-015 done  output  1  high after chart fully flushed until next start.

Function
REQ-016 The block SHALL implement states IDLE, FETCH, WAIT_COMMIT, FLUSH, DONE.
REQ-017 IDLE: start -> FETCH with chart_addr=0, entries_loaded=0, beat counter=0, arrow_array=0, indicators=00.
REQ-018 FETCH: chart_req SHALL stay high, chart_addr stable, until chart_valid; on that cycle chart_data is captured into next_code, chart_req drops the following cycle, state -> WAIT_COMMIT.
REQ-019 chart_valid while chart_req is low SHALL be ignored.
REQ-020 Beat counter SHALL run 0..BEAT_CYCLES-1 in FETCH, WAIT_COMMIT, FLUSH; wrap sets beat_pending.
REQ-021 Shift occurs on a cycle with frame_end=1 AND (beat_pending=1 or counter wrapping this cycle) AND next_code captured: arrow_array <= {arrow_array[74:0], next_code}; beat_pending clears; slot 25 contents discarded.
REQ-022 If the beat is due but the fetch is outstanding, the shift SHALL wait for the next qualifying frame_end; a second wrap while pending SHALL NOT queue a second shift.
REQ-023 After each shift in WAIT_COMMIT: entries_loaded increments; if < CHART_LEN, chart_addr increments and state -> FETCH; else -> FLUSH with flush count 0.
REQ-024 FLUSH: each shift inserts 000 (no fetch); after 26 flush shifts -> DONE.
REQ-025 playing SHALL be high in FETCH, WAIT_COMMIT, FLUSH; done high only in DONE; DONE + start -> IDLE-equivalent restart (REQ-017) same edge.
REQ-026 start outside IDLE/DONE SHALL be ignored.
REQ-027 Judgement, per player independently, only while playing: on a cycle where buttons != 000 and previous-cycle buttons == 000 (press edge):
REQ-028   slot 25 == buttons -> indicator 11; else slot 24 == buttons -> 10; else 01; compared against arrow_array before any same-cycle shift.
REQ-029 Only the first press edge per player per beat (between shifts) SHALL be judged; later edges ignored until the next shift.
REQ-030 Indicators SHALL hold their last value until next judgement, start, or reset.
REQ-031 All outputs SHALL be registered; shift and indicator updates visible the cycle after the qualifying edge.

Reset
REQ-032 reset SHALL override all inputs, including mid-fetch or mid-shift: state IDLE, arrow_array=0, chart_req=0, chart_addr=0, indicators=00, playing=0, done=0, counters and beat_pending cleared, press history cleared.

Verification (BEAT_CYCLES=4, CHART_LEN=2, ROM latency 3 cycles unless stated)
REQ-033 Chart {001,100}, frame_end every cycle -> first shift: slot0=001; next: slot0=100, slot1=001; after 26 more shifts arrow_array=0, done=1, playing=0.
REQ-034 ROM latency 10 cycles, frame_end every cycle -> beat wrap precedes valid; exactly one shift occurs, on first frame_end after capture; no double shift.
REQ-035 frame_end withheld 12 cycles after wrap -> arrow_array unchanged until frame_end; shifts by exactly one slot.
REQ-036 Slot25=010, slot24=001: p1 presses 010 (edge), p2 presses 001 same cycle -> p1_indicator=11, p2_indicator=10; p1 presses 011 again same beat -> p1_indicator stays 11.
REQ-037 reset asserted while chart_req=1 -> next cycle chart_req=0, arrow_array=0, playing=0; late chart_valid ignored; new start fetches addr 0.
